// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file write-back path: the write request
// carried through the load queue and the write-source select.
package rf_wb_pkg;

  localparam int RF_RS = 5;
  localparam int RF_RD = 32;

  typedef struct packed {
    logic [RF_RS-1:0] rd;
    logic [RF_RD-1:0] wd;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LQ
  } wb_src_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Load-return queue: circular buffer of write requests with a separate
// occupancy counter, plus per-entry valid/rd vectors for hazard tracking.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter  int LQ_DEPTH = 4,
  localparam int PW       = $clog2(LQ_DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  wb_req_t                          push_req,
  input  logic                             pop,
  output wb_req_t                          head,
  output logic [CW-1:0]                    count,
  output logic                             empty,
  output logic                             full,
  output logic [LQ_DEPTH-1:0]              entry_valid,
  output logic [LQ_DEPTH-1:0][RF_RS-1:0]   entry_rd
);

  wb_req_t       mem [LQ_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign empty = (count == '0);
  assign full  = (count == CW'(LQ_DEPTH));
  assign head  = mem[rd_ptr];

  // NOTE: the storage array has no reset; validity is carried by the
  // pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    for (int i = 0; i < LQ_DEPTH; i++) begin
      logic [PW-1:0] off;
      off            = PW'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, off} < count);
      entry_rd[i]    = mem[i].rd;
    end
  end

  assert property (@(posedge clk) disable iff (!rst) push |-> (!full || pop));
  assert property (@(posedge clk) disable iff (!rst) pop  |-> !empty);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU results take the port, queued load
// returns drain when the ALU is idle. Optional WB_BYPASS_EN lets a load write
// straight through when the queue is empty and the ALU is idle.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int RS       = RF_RS,
  parameter int RD       = RF_RD,
  parameter int LQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [RS-1:0]               alu_rd,
  input  logic [RD-1:0]               alu_wd,
  output logic                        alu_ready,
  input  logic                        ld_valid,
  input  logic [RS-1:0]               ld_rd,
  input  logic [RD-1:0]               ld_wd,
  output logic                        ld_ready,
  output logic [RS-1:0]               rf_rd,
  output logic [RD-1:0]               rf_wd,
  output logic                        rf_write_en,
  output logic [2**RS-1:0]            pend_mask,
  output logic [$clog2(LQ_DEPTH):0]   lq_count
);

  wb_req_t                         alu_req;
  wb_req_t                         ld_req;
  wb_req_t                         head;
  wb_req_t                         sel_req;
  wb_src_e                         sel;
  logic                            push;
  logic                            pop;
  logic                            empty;
  logic                            full;
  logic                            alu_fire;
  logic                            ld_fire;
  logic [LQ_DEPTH-1:0]             entry_valid;
  logic [LQ_DEPTH-1:0][RF_RS-1:0]  entry_rd;

  assign alu_req = '{rd: alu_rd, wd: alu_wd};
  assign ld_req  = '{rd: ld_rd,  wd: ld_wd};

  rf_wb_fifo #(.LQ_DEPTH(LQ_DEPTH)) u_lq (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_req    (ld_req),
    .pop         (pop),
    .head        (head),
    .count       (lq_count),
    .empty       (empty),
    .full        (full),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (entry_valid[i] && entry_rd[i] != '0) pend_mask[entry_rd[i]] = 1'b1;
    end
  end

  // A queued older load to the same rd must land before a newer ALU value.
  assign ld_ready  = !full;
  assign alu_ready = !full && !(alu_rd != '0 && pend_mask[alu_rd]);
  assign alu_fire  = alu_valid && alu_ready;
  assign ld_fire   = ld_valid && ld_ready;

  always_comb begin
    sel     = WB_NONE;
    sel_req = head;
    pop     = 1'b0;
    push    = ld_fire;
    if (alu_fire) begin
      sel     = WB_ALU;
      sel_req = alu_req;
    end else if (!empty) begin
      sel     = WB_LQ;
      sel_req = head;
      pop     = 1'b1;
    end
`ifdef WB_BYPASS_EN
    else if (ld_fire) begin
      sel     = WB_LQ;
      sel_req = ld_req;
      push    = 1'b0;
    end
`endif
  end

  // Writes to x0 are consumed but never strobed into the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_rd       <= '0;
      rf_wd       <= '0;
      rf_write_en <= 1'b0;
    end else begin
      rf_write_en <= (sel != WB_NONE) && (sel_req.rd != '0);
      if (sel != WB_NONE) begin
        rf_rd <= sel_req.rd;
        rf_wd <= sel_req.wd;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst)
                   (sel == WB_ALU) |-> (alu_fire && !pop));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios then random traffic, all
// checked against a queue-based model of the write-back rules.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int LQ = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_wd = '0;
  logic        alu_ready;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_wd = '0;
  logic        ld_ready;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        rf_write_en;
  logic [31:0] pend_mask;
  logic [2:0]  lq_count;

  rf_wb_arbiter #(.RS(5), .RD(32), .LQ_DEPTH(LQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_wd      (alu_wd),
    .alu_ready   (alu_ready),
    .ld_valid    (ld_valid),
    .ld_rd       (ld_rd),
    .ld_wd       (ld_wd),
    .ld_ready    (ld_ready),
    .rf_rd       (rf_rd),
    .rf_wd       (rf_wd),
    .rf_write_en (rf_write_en),
    .pend_mask   (pend_mask),
    .lq_count    (lq_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  wb_req_t     q[$];
  logic [31:0] rf_img [32];
  bit          last_axf = 1'b0;
  bit          last_lxf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (q[i]) if (q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) if (q[i].rd != 5'd0) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  // One clock: check handshake state mid-cycle, predict the write, check it.
  task automatic step();
    bit exp_ar, exp_lr, axf, lxf, byp, wen, empty0;
    wb_req_t w;
    @(negedge clk); #1;
    exp_lr = (q.size() != LQ);
    exp_ar = exp_lr && !pending(alu_rd);
    check("ld_ready",  64'(ld_ready),  64'(exp_lr));
    check("alu_ready", 64'(alu_ready), 64'(exp_ar));
    check("pend_mask", 64'(pend_mask), 64'(model_mask()));
    check("lq_count",  64'(lq_count),  64'(q.size()));
    axf = alu_valid && exp_ar;
    lxf = ld_valid && exp_lr;
    empty0 = (q.size() == 0);
    byp = 1'b0;
    wen = 1'b0;
    w   = '0;
    if (axf) begin
      w = '{rd: alu_rd, wd: alu_wd};
      wen = (alu_rd != 5'd0);
    end else if (!empty0) begin
      w = q.pop_front();
      wen = (w.rd != 5'd0);
    end else if (BYP && lxf) begin
      w = '{rd: ld_rd, wd: ld_wd};
      wen = (ld_rd != 5'd0);
      byp = 1'b1;
    end
    if (lxf && !byp) q.push_back('{rd: ld_rd, wd: ld_wd});
    @(posedge clk); #1;
    check("rf_write_en", 64'(rf_write_en), 64'(wen));
    if (wen) begin
      check("rf_rd", 64'(rf_rd), 64'(w.rd));
      check("rf_wd", 64'(rf_wd), 64'(w.wd));
    end
    if (rf_write_en) rf_img[rf_rd] = rf_wd;
    last_axf = axf;
    last_lxf = lxf;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int ld_idx;
    foreach (rf_img[i]) rf_img[i] = '0;

    // Reset with both producers offering.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
    ld_valid  = 1'b1; ld_rd  = 5'd9; ld_wd  = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write_en", 64'(rf_write_en), 64'd0);
    check("rst_rf_rd",    64'(rf_rd),       64'd0);
    check("rst_rf_wd",    64'(rf_wd),       64'd0);
    check("rst_pend",     64'(pend_mask),   64'd0);
    check("rst_count",    64'(lq_count),    64'd0);
    check("rst_alu_rdy",  64'(alu_ready),   64'd1);
    check("rst_ld_rdy",   64'(ld_ready),    64'd1);
    rst = 1'b1;
    ld_valid = 1'b0;
    step();
    check("first_alu_en", 64'(rf_write_en), 64'd1);
    check("first_alu_rd", 64'(rf_rd),       64'd5);
    check("first_alu_wd", 64'(rf_wd),       64'hDEADBEEF);
    alu_valid = 1'b0;

    // Single load with the ALU idle.
    ld_valid = 1'b1; ld_rd = 5'd3; ld_wd = 32'h11;
    step();
    ld_valid = 1'b0;
    check("load_pend3_set", 64'(pend_mask[3]), 64'(!BYP));
    check("load_early_en",  64'(rf_write_en),  64'(BYP));
    step();
    check("load_late_en", 64'(rf_write_en),  64'(!BYP));
    check("load_pend3_clr", 64'(pend_mask[3]), 64'd0);
    step();

    // Fill the queue while the ALU streams, then watch the drain.
    n = 0; ld_idx = 1;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_wd = $urandom;
    ld_valid  = 1'b1; ld_rd  = 5'd1;  ld_wd  = 32'h100;
    for (int k = 0; k < 12; k++) begin
      step();
      if (last_axf) begin
        n++;
        alu_rd = 5'(10 + n);
        alu_wd = $urandom;
      end
      if (last_lxf) begin
        ld_idx++;
        if (ld_idx <= 4) begin
          ld_rd = 5'(ld_idx);
          ld_wd = 32'h100 + 32'(ld_idx);
        end else begin
          ld_valid = 1'b0;
          if (ld_idx == 5) begin
            check("full_count",   64'(lq_count),  64'd4);
            check("full_alu_rdy", 64'(alu_ready), 64'd0);
            check("full_ld_rdy",  64'(ld_ready),  64'd0);
          end
        end
      end
    end
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    for (int k = 0; k < 8 && q.size() != 0; k++) step();
    check("drain_empty", 64'(q.size()), 64'd0);
    step();

    // WAW guard on x7.
    ld_valid = 1'b1; ld_rd = 5'd7; ld_wd = 32'h77;
    step();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'hA1A1A1A1;
    #1;
    check("waw_alu_rdy", 64'(alu_ready), 64'(BYP));
    for (int k = 0; k < 4; k++) begin
      step();
      if (last_axf) alu_valid = 1'b0;
    end
    check("waw_final_x7", 64'(rf_img[7]), 64'hA1A1A1A1);

    // x0 from both producers.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'h1;
    ld_valid  = 1'b1; ld_rd  = 5'd0; ld_wd  = 32'h2;
    step();
    check("x0_pend0", 64'(pend_mask[0]), 64'd0);
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    repeat (3) step();

    // Reset with three loads queued behind ALU traffic.
    alu_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      alu_rd = 5'(20 + k); alu_wd = $urandom;
      ld_valid = 1'b1; ld_rd = 5'(12 + k); ld_wd = $urandom;
      step();
    end
    check("pre_rst_count", 64'(lq_count), 64'd3);
    rst = 1'b0;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    #1;
    check("midrst_count", 64'(lq_count),    64'd0);
    check("midrst_pend",  64'(pend_mask),   64'd0);
    check("midrst_en",    64'(rf_write_en), 64'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) step();

    // Random traffic with producers holding payload until accepted.
    last_axf = 1'b0;
    last_lxf = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!alu_valid || last_axf) begin
        alu_valid = ($urandom_range(3) != 0);
        alu_rd    = 5'($urandom_range(7));
        alu_wd    = $urandom;
      end
      if (!ld_valid || last_lxf) begin
        ld_valid = ($urandom_range(1) != 0);
        ld_rd    = 5'($urandom_range(7));
        ld_wd    = $urandom;
      end
      step();
    end
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-side driver for the core's register file.
- Merges two result producers into the single RF write port (rd / wd / write_en), one write per cycle:
  - ALU/jump results, one per cycle, never stalled upstream in normal flow.
  - Load results arriving out of step from the data-memory interface.
- Buffers load returns in a small FIFO.
- Exports a per-register pending mask so issue logic can detect load-use hazards.

Parameters:
- RS, 5, register index width.
- RD, 32, data width.
- LQ_DEPTH, 4, load-queue entries (power of two, ≥2).

Ports:
- clk  input  1  core clock
- rst  input  1  reset, asynchronous, active-low
- alu_valid  input  1  ALU result offered
- alu_rd  input  RS  ALU destination index
- alu_wd  input  RD  ALU result data
- alu_ready  output  1  ALU result accepted this cycle when alu_valid=1
- ld_valid  input  1  load result offered
- ld_rd  input  RS  load destination index
- ld_wd  input  RD  load data
- ld_ready  output  1  load result accepted this cycle when ld_valid=1
- rf_rd  output  RS  RF write index
- rf_wd  output  RD  RF write data
- rf_write_en  output  1  RF write strobe
- pend_mask  output  2**RS  bit i=1 while a load to x[i] is queued
- lq_count  output  $clog2(LQ_DEPTH)+1  load-queue occupancy

Behaviour:
Clock and reset:
- One clock, clk.
- rst is asynchronous, active-low.
- While rst=0:
  - FIFO emptied; rf_rd=0, rf_wd=0, rf_write_en=0; pend_mask=0; lq_count=0.
  - alu_ready and ld_ready read 1.
- Reset mid-operation discards all queued loads and any pending write with no RF write issued.

Handshakes:
- valid/ready; a transfer occurs when valid&&ready at posedge clk.
- Producers hold payload stable until accepted.
- ld_ready = (lq_count != LQ_DEPTH). Combinational from state only; there is no same-cycle full-drain pass-through.
- alu_ready = 0 if:
  - lq_count==LQ_DEPTH (drain priority), or
  - alu_rd!=0 && pend_mask[alu_rd] (WAW guard: an older queued load must not overwrite a newer ALU value).
- Otherwise alu_ready = 1.

Write selection, evaluated each cycle:
1. ALU accepted → ALU result written.
2. Else, FIFO non-empty → FIFO head popped and written.
3. Else → no write.

Latency:
- Output regs rf_rd/rf_wd/rf_write_en are registered.
- ALU accepted in cycle N → rf_write_en=1 in cycle N+1.
- Load accepted in cycle N → enqueued at end of N → earliest write N+2.
- rf_write_en is a single-cycle pulse per write; 0 when no write was selected.

x0 handling:
- A selected entry with rd=0 is consumed (popped/accepted) but rf_write_en stays 0.
- x0 is never marked in pend_mask.

Simultaneous events:
- Enqueue and pop in the same cycle: lq_count unchanged, pointers both advance.
- Enqueue when one slot is free makes the FIFO full next cycle; alu_ready drops then.

Pointers and pend_mask:
- Read/write pointers of width $clog2(LQ_DEPTH) wrap modulo LQ_DEPTH.
- lq_count is kept separately to distinguish full from empty.
- pend_mask[i] = OR over valid FIFO entries with rd==i, i≠0. It is combinational from FIFO contents.
- Two queued loads to the same rd keep the bit set until both have been popped.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: when the FIFO is empty and no ALU transfer occurs, an accepted load is written directly. The load latency becomes N+1 and it is not enqueued; pend_mask is not set for it.
- Undefined: every load goes through the FIFO, with latency ≥ N+2 as above.

Decomposition:
- Package rf_wb_pkg:
  - localparams RF_RS=5, RF_RD=32.
  - typedef wb_req_t {logic [RF_RS-1:0] rd; logic [RF_RD-1:0] wd;}.
  - typedef wb_src_e {WB_NONE, WB_ALU, WB_LQ}, used for the select mux and assertions.
- Sub-module rf_wb_fifo:
  - Parameterised on LQ_DEPTH; stores wb_req_t.
  - Exposes push/pop/count/entry-valid + rd vectors for pend_mask generation.
- The arbiter top contains selection, x0 suppression and output registers.

Test Plan:
- Reset: hold rst=0 with ld_valid=1 and alu_valid=1 → outputs 0, pend_mask=0. Release rst → first ALU transfer (rd=5, wd=0xDEADBEEF) gives rf_write_en=1, rf_rd=5, rf_wd=0xDEADBEEF one cycle later.
- Load path: load rd=3, wd=0x11, ALU idle → pend_mask[3]=1 for one cycle, then write rd=3/0x11 at N+2 and pend_mask[3]=0 after. With WB_BYPASS_EN: write at N+1, pend_mask[3] never set.
- Full drain: queue 4 loads (rd 1..4) while ALU streams rd=10..; ALU is prioritised until lq_count=4 → ld_ready=0, alu_ready=0; next write rd=1, then ALU resumes.
- WAW guard: load rd=7 queued, ALU offers rd=7 → alu_ready=0 until the load write to x7 completes; ALU write to x7 follows, final RF x7 = ALU data.
- x0: ALU rd=0 and load rd=0 → both consumed, rf_write_en never asserted, pend_mask[0]=0.
- Mid-op reset: 3 loads queued, assert rst → lq_count=0, pend_mask=0 immediately; no queued write appears after release.
